// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Misaligned or beyond the end of instruction memory.
    function automatic logic pc_illegal(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] limit);
        return (pc[1:0] != 2'b00) || (pc >= limit);
    endfunction

endpackage

// File: rtl/fetch_ctrl_fifo.sv
// Synchronous FIFO of fetch entries; flush wins over push/pop, push+pop allowed at full.
module fetch_fifo
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  fetch_entry_t wr_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t rd_data,
    output logic         empty,
    output logic         full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    fetch_entry_t   mem_q [DEPTH];
    fetch_entry_t   mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty && !flush;
        do_push  = push && !flush && (!full || do_pop);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (do_push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, fills a prefetch FIFO from
// combinational instruction memory, handles redirects and illegal fetch addresses.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     FIFO_DEPTH = 2,
    parameter int unsigned     IMEM_WORDS = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            run,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rd,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    output logic            fault,
    output logic [XLEN-1:0] fault_pc
);

    localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(IMEM_WORDS * 4);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] fault_pc_q, fault_pc_d;

    logic            fifo_empty;
    logic            fifo_full;
    fetch_entry_t    head;
    fetch_entry_t    tail;
    logic            pop;
    logic            redirect_take;
    logic            redirect_bad;
    logic            fetch_try;
    logic            fetch_bad;
    logic            push;

    assign pop           = inst_valid && inst_ready;
    assign redirect_take = redirect_valid && (state_q != FAULT);
    assign redirect_bad  = redirect_take && pc_illegal(redirect_pc, PC_LIMIT);
    // A fetch is attempted only when the FIFO can take it this cycle.
    assign fetch_try     = (state_q == FETCH) && !redirect_valid && (!fifo_full || pop);
    assign fetch_bad     = fetch_try && pc_illegal(pc_q, PC_LIMIT);
    assign push          = fetch_try && !fetch_bad;
    assign tail          = '{inst: imem_rd, pc: pc_q};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wr_data (tail),
        .pop     (pop),
        .flush   (redirect_take),
        .rd_data (head),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;

        case (state_q)
            IDLE:    if (run)  state_d = FETCH;
            FETCH:   if (!run) state_d = IDLE;
            default: state_d = FAULT;
        endcase

        if (redirect_take) begin
            if (redirect_bad) begin
                state_d    = FAULT;
                fault_d    = 1'b1;
                fault_pc_d = redirect_pc;
            end else begin
                pc_d = redirect_pc;
            end
        end else if (fetch_bad) begin
            state_d    = FAULT;
            fault_d    = 1'b1;
            fault_pc_d = pc_q;
        end else if (push) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    assign imem_addr  = pc_q;
    assign inst_valid = !fifo_empty;
    assign inst       = fifo_empty ? '0 : head.inst;
    assign inst_pc    = fifo_empty ? '0 : head.pc;
    assign fault      = fault_q;
    assign fault_pc   = fault_pc_q;

endmodule
